// File: rtl/code_lock_fsm.sv
// Code lock controller: collects DIGITS digits, compares them with CODE,
// opens for OPEN_CYCLES cycles on a match and locks out for LOCK_CYCLES
// cycles after MAX_TRIES consecutive mismatches.
//
// state  | meaning
// IDLE   | waiting for the first digit, entry buffer empty
// ENTER  | collecting the remaining digits
// CHECK  | one cycle to compare the entry with CODE
// OPEN   | lock released, timer counting down
// FAIL   | one-cycle wrong-code indication
// LOCKED | too many failures, all input ignored until timer expires
module code_lock_fsm #(
    parameter int                            DIGITS      = 4,
    parameter int                            DIGIT_W     = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]     CODE        = 16'h1234,
    parameter int                            MAX_TRIES   = 3,
    parameter int                            OPEN_CYCLES = 8,
    parameter int                            LOCK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    output logic               unlocked,
    output logic               error,
    output logic               alarm,
    output logic               busy,
    output logic [5:0]         state_o
);

    localparam int BUF_W  = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMAX   = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TIM_W  = $clog2(TMAX + 1);

    localparam logic [5:0] S_IDLE   = 6'b000001;
    localparam logic [5:0] S_ENTER  = 6'b000010;
    localparam logic [5:0] S_CHECK  = 6'b000100;
    localparam logic [5:0] S_OPEN   = 6'b001000;
    localparam logic [5:0] S_FAIL   = 6'b010000;
    localparam logic [5:0] S_LOCKED = 6'b100000;

    logic [5:0]        state;
    logic [5:0]        next_state;
    logic [BUF_W-1:0]  entry_buf;
    logic [CNT_W-1:0]  digit_cnt;
    logic [FAIL_W-1:0] fail_cnt;
    logic [TIM_W-1:0]  timer;

    logic              last_digit;
    logic              match;
    logic [FAIL_W-1:0] fail_inc;
    logic              lock_hit;
    logic              timer_done;

    assign last_digit = (digit_cnt == CNT_W'(DIGITS - 1));
    assign match      = (entry_buf == CODE);
    assign fail_inc   = fail_cnt + FAIL_W'(1);
    assign lock_hit   = (fail_inc == FAIL_W'(MAX_TRIES));
    assign timer_done = (timer == '0);

    // State register plus entry buffer, digit/fail counters and down-counting timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            entry_buf <= '0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            timer     <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE, S_ENTER: begin
                    if (digit_valid && !clear) begin
                        entry_buf <= (entry_buf << DIGIT_W) | BUF_W'(digit);
                        digit_cnt <= digit_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        fail_cnt <= '0;
                        timer    <= TIM_W'(OPEN_CYCLES - 1);
                    end else begin
                        fail_cnt <= fail_inc;
                        if (lock_hit) begin
                            timer <= TIM_W'(LOCK_CYCLES - 1);
                        end
                    end
                end
                S_OPEN: begin
                    if (!timer_done) begin
                        timer <= timer - TIM_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (timer_done) begin
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - TIM_W'(1);
                    end
                end
                S_FAIL: begin
                end
                default: begin
                    fail_cnt <= '0;
                    timer    <= '0;
                end
            endcase
            // Every return to IDLE starts a fresh entry.
            if (next_state == S_IDLE) begin
                entry_buf <= '0;
                digit_cnt <= '0;
            end
        end
    end

    // Next-state decode; clear takes priority over a simultaneous digit.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_ENTER: begin
                if (clear) begin
                    next_state = S_IDLE;
                end else if (digit_valid) begin
                    next_state = last_digit ? S_CHECK : S_ENTER;
                end
            end
            S_CHECK: begin
                if (match) begin
                    next_state = S_OPEN;
                end else if (lock_hit) begin
                    next_state = S_LOCKED;
                end else begin
                    next_state = S_FAIL;
                end
            end
            S_OPEN, S_LOCKED: begin
                if (timer_done) begin
                    next_state = S_IDLE;
                end
            end
            S_FAIL:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        unlocked = (state == S_OPEN);
        error    = (state == S_FAIL);
        alarm    = (state == S_LOCKED);
        busy     = (state == S_CHECK) || (state == S_OPEN) ||
                   (state == S_FAIL)  || (state == S_LOCKED);
        state_o  = state;
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm with default parameters.
module tb_code_lock_fsm;

    localparam logic [5:0] S_IDLE   = 6'b000001;
    localparam logic [5:0] S_ENTER  = 6'b000010;
    localparam logic [5:0] S_CHECK  = 6'b000100;
    localparam logic [5:0] S_OPEN   = 6'b001000;
    localparam logic [5:0] S_FAIL   = 6'b010000;
    localparam logic [5:0] S_LOCKED = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       unlocked;
    logic       error;
    logic       alarm;
    logic       busy;
    logic [5:0] state_o;

    int checks = 0;
    int errors = 0;

    code_lock_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .unlocked    (unlocked),
        .error       (error),
        .alarm       (alarm),
        .busy        (busy),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // advance one rising edge, leave signals settled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present four digits MS first on consecutive cycles; ends in CHECK
    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) begin
            digit_valid = 1'b1;
            digit       = c[i*4 +: 4];
            step();
        end
        digit_valid = 1'b0;
        digit       = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0; digit_valid = 1'b0; digit = 4'h0; clear = 1'b0;
        step();
        step();
        checks++;
        if (state_o !== S_IDLE || unlocked !== 1'b0 || error !== 1'b0 ||
            alarm !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: state_o=%b u=%b e=%b a=%b b=%b, want 000001 0 0 0 0",
                     state_o, unlocked, error, alarm, busy);
        end
        reset = 1'b1;
        digit_valid = 1'b1;
        digit = 4'h1;
        step();
        checks++;
        if (state_o !== S_ENTER) begin
            errors++;
            $display("FAIL first_digit_after_reset: state_o=%b want %b", state_o, S_ENTER);
        end
        digit_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (state_o !== S_IDLE) begin
            errors++;
            $display("FAIL clear_in_enter: state_o=%b want %b", state_o, S_IDLE);
        end
    endtask

    // correct code: CHECK one cycle, unlocked exactly 8 cycles, then IDLE
    task automatic test_open();
        digit_valid = 1'b1; digit = 4'h1;
        step();
        checks++;
        if (state_o !== S_ENTER || busy !== 1'b0) begin
            errors++;
            $display("FAIL open_after_first: state_o=%b busy=%b want %b 0", state_o, busy, S_ENTER);
        end
        for (int i = 2; i <= 4; i++) begin
            digit = 4'(i);
            step();
        end
        digit_valid = 1'b0;
        checks++;
        if (state_o !== S_CHECK || busy !== 1'b1 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL open_check: state_o=%b busy=%b u=%b want %b 1 0",
                     state_o, busy, unlocked, S_CHECK);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (unlocked !== 1'b1 || state_o !== S_OPEN || busy !== 1'b1) begin
                errors++;
                $display("FAIL open_cycle%0d: unlocked=%b state_o=%b want 1 %b",
                         i, unlocked, state_o, S_OPEN);
            end
            step();
        end
        checks++;
        if (unlocked !== 1'b0 || state_o !== S_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL open_end: unlocked=%b state_o=%b want 0 %b", unlocked, state_o, S_IDLE);
        end
    endtask

    // wrong code: one FAIL cycle then IDLE (fail count becomes 1)
    task automatic test_wrong();
        enter_code(16'h1235);
        checks++;
        if (state_o !== S_CHECK) begin
            errors++;
            $display("FAIL wrong_check: state_o=%b want %b", state_o, S_CHECK);
        end
        step();
        checks++;
        if (error !== 1'b1 || state_o !== S_FAIL || busy !== 1'b1) begin
            errors++;
            $display("FAIL wrong_error: error=%b state_o=%b want 1 %b", error, state_o, S_FAIL);
        end
        step();
        checks++;
        if (error !== 1'b0 || state_o !== S_IDLE) begin
            errors++;
            $display("FAIL wrong_end: error=%b state_o=%b want 0 %b", error, state_o, S_IDLE);
        end
    endtask

    // second failure still FAIL (not LOCKED), then right code opens and resets count
    task automatic test_retry_opens();
        enter_code(16'h9999);
        step();
        checks++;
        if (state_o !== S_FAIL) begin
            errors++;
            $display("FAIL retry_second_wrong: state_o=%b want %b", state_o, S_FAIL);
        end
        step();
        enter_code(16'h1234);
        step();
        checks++;
        if (state_o !== S_OPEN || unlocked !== 1'b1) begin
            errors++;
            $display("FAIL retry_open: state_o=%b unlocked=%b want %b 1", state_o, unlocked, S_OPEN);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (state_o !== S_IDLE) begin
            errors++;
            $display("FAIL retry_open_end: state_o=%b want %b", state_o, S_IDLE);
        end
        // count was reset by the open: two more failures must not lock
        for (int k = 0; k < 2; k++) begin
            enter_code(16'h0000);
            step();
            checks++;
            if (state_o !== S_FAIL) begin
                errors++;
                $display("FAIL retry_count_reset%0d: state_o=%b want %b", k, state_o, S_FAIL);
            end
            step();
        end
        // third consecutive failure locks; wait out the lockout
        enter_code(16'h0000);
        step();
        checks++;
        if (state_o !== S_LOCKED) begin
            errors++;
            $display("FAIL retry_third_locks: state_o=%b want %b", state_o, S_LOCKED);
        end
        for (int i = 0; i < 16; i++) step();
    endtask

    // three wrong codes from count 0 -> alarm exactly 16 cycles, digits ignored
    task automatic test_lockout();
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h4321);
            step();
            if (k < 2) begin
                checks++;
                if (state_o !== S_FAIL) begin
                    errors++;
                    $display("FAIL lock_pre%0d: state_o=%b want %b", k, state_o, S_FAIL);
                end
                step();
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (alarm !== 1'b1 || state_o !== S_LOCKED || busy !== 1'b1) begin
                errors++;
                $display("FAIL lock_cycle%0d: alarm=%b state_o=%b want 1 %b",
                         i, alarm, state_o, S_LOCKED);
            end
            digit_valid = 1'b1;
            digit       = 4'(i);
            clear       = i[0];
            step();
        end
        digit_valid = 1'b0; clear = 1'b0;
        checks++;
        if (alarm !== 1'b0 || state_o !== S_IDLE) begin
            errors++;
            $display("FAIL lock_end: alarm=%b state_o=%b want 0 %b", alarm, state_o, S_IDLE);
        end
        // fail count is zero again: two wrong codes give FAIL, not LOCKED
        for (int k = 0; k < 2; k++) begin
            enter_code(16'h5555);
            step();
            checks++;
            if (state_o !== S_FAIL) begin
                errors++;
                $display("FAIL lock_count_cleared%0d: state_o=%b want %b", k, state_o, S_FAIL);
            end
            step();
        end
    endtask

    // clear beats digit_valid; a fresh 1234 then opens
    task automatic test_clear();
        digit_valid = 1'b1;
        digit = 4'h1; step();
        digit = 4'h2; step();
        digit = 4'h3; clear = 1'b1; step();
        clear = 1'b0; digit_valid = 1'b0;
        checks++;
        if (state_o !== S_IDLE) begin
            errors++;
            $display("FAIL clear_with_digit: state_o=%b want %b", state_o, S_IDLE);
        end
        enter_code(16'h1234);
        step();
        checks++;
        if (state_o !== S_OPEN || unlocked !== 1'b1) begin
            errors++;
            $display("FAIL clear_then_open: state_o=%b unlocked=%b want %b 1",
                     state_o, unlocked, S_OPEN);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    // reset between edges during LOCKED takes effect immediately
    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h7777);
            step();
            if (k < 2) step();
        end
        step();
        step();
        checks++;
        if (state_o !== S_LOCKED) begin
            errors++;
            $display("FAIL async_pre: state_o=%b want %b", state_o, S_LOCKED);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state_o !== S_IDLE || alarm !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state_o=%b alarm=%b busy=%b want %b 0 0",
                     state_o, alarm, busy, S_IDLE);
        end
        step();
        reset = 1'b1;
        enter_code(16'h1234);
        step();
        checks++;
        if (state_o !== S_OPEN) begin
            errors++;
            $display("FAIL async_recover_open: state_o=%b want %b", state_o, S_OPEN);
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_wrong();
        test_retry_opens();
        test_lockout();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
CODE_LOCK_FSM -- requirements
Module: code_lock_fsm

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of digits per code entry (>=1).
REQ-002 SHALL have parameter DIGIT_W, default 4, bits per digit.
REQ-003 SHALL have parameter CODE, default 16'h1234, width DIGITS*DIGIT_W; first digit entered occupies the MS digit.
REQ-004 SHALL have parameter MAX_TRIES, default 3, consecutive failures that trigger lockout (>=1).
REQ-005 SHALL have parameter OPEN_CYCLES, default 8, cycles spent in OPEN (>=1).
REQ-006 SHALL have parameter LOCK_CYCLES, default 16, cycles spent in LOCKED (>=1).
REQ-007 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port digit_valid  input  1  digit present this cycle.
REQ-010 SHALL have port digit  input  DIGIT_W  digit value, sampled only when digit_valid=1.
REQ-011 SHALL have port clear  input  1  abort the current entry.
REQ-012 SHALL have port unlocked  output  1  high while in OPEN.
REQ-013 SHALL have port error  output  1  high while in FAIL.
REQ-014 SHALL have port alarm  output  1  high while in LOCKED.
REQ-015 SHALL have port busy  output  1  high in CHECK, OPEN, FAIL or LOCKED.
REQ-016 SHALL have port state_o  output  6  one-hot state register, for debug.

Function
REQ-017 SHALL encode states one-hot: IDLE=6'b000001, ENTER=000010, CHECK=000100, OPEN=001000, FAIL=010000, LOCKED=100000.
REQ-018 SHALL use one registered sequential block and one combinational next-state block; nextState defaults to the current state.
REQ-019 SHALL derive all outputs as Moore functions of the state register only, so they change only at clock edges.
REQ-020 SHALL, in IDLE or ENTER with digit_valid=1 and clear=0, shift the digit into the entry buffer and increment the digit counter.
REQ-021 SHALL move IDLE->ENTER on the first accepted digit, or IDLE->CHECK when DIGITS==1.
REQ-022 SHALL move ENTER->CHECK on the edge that accepts digit number DIGITS.
REQ-023 SHALL, on clear=1 in IDLE or ENTER, return to IDLE and zero buffer and digit counter; clear beats a simultaneous digit_valid.
REQ-024 SHALL stay in CHECK one cycle and compare the buffer with CODE.
REQ-025 SHALL, on a match, go to OPEN and zero the fail counter.
REQ-026 SHALL, on a mismatch, increment the fail counter; go to LOCKED if the new count equals MAX_TRIES, otherwise go to FAIL.
REQ-027 SHALL stay in FAIL exactly one cycle, then go to IDLE.
REQ-028 SHALL stay in OPEN exactly OPEN_CYCLES cycles, then go to IDLE.
REQ-029 SHALL stay in LOCKED exactly LOCK_CYCLES cycles, then go to IDLE and zero the fail counter.
REQ-030 SHALL ignore digit_valid and clear in CHECK, OPEN, FAIL and LOCKED.
REQ-031 SHALL size the fail counter as $clog2(MAX_TRIES+1) bits and the timer as $clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1) bits, with no wrap.
REQ-032 SHALL clear the buffer and digit counter on every transition into IDLE.
REQ-033 SHALL treat any state encoding that is not one-hot (default branch) as IDLE on the next edge, with counters zeroed.

Reset
REQ-034 SHALL, while reset=0 and without waiting for clk, force state=IDLE, buffer=0, digit counter=0, fail counter=0, timer=0.
REQ-035 SHALL hold unlocked=0, error=0, alarm=0, busy=0 and state_o=6'b000001 during reset.
REQ-036 SHALL abort any operation in progress (OPEN, LOCKED, partial entry) when reset asserts.
REQ-037 SHALL accept a digit on the first clk edge after reset deasserts.

Verification
REQ-038 SHALL cover: digits 1,2,3,4 on consecutive cycles -> CHECK for 1 cycle, then unlocked=1 for exactly 8 cycles, then IDLE.
REQ-039 SHALL cover: digits 1,2,3,5 -> error=1 for 1 cycle, fail count 1, back in IDLE.
REQ-040 SHALL cover: three wrong codes in a row -> alarm=1 for exactly 16 cycles; digits are ignored meanwhile; fail count is 0 afterwards.
REQ-041 SHALL cover: two wrong codes then code 1234 -> OPEN, and the fail counter resets to 0.
REQ-042 SHALL cover: digits 1,2, then clear together with digit_valid -> IDLE; a following entry of 1,2,3,4 opens.
REQ-043 SHALL cover: reset asserted mid-LOCKED between clock edges -> state_o=000001 and alarm=0 immediately.
